// File: rtl/ctrl_pkg.sv
// Shared control-unit definitions: opcode map, executor indices, dispatcher states, error codes.
// State PAUSE exists only when INSTR_DISPATCH_SINGLE_STEP_EN is defined.
package ctrl_pkg;

  localparam logic [3:0] OP_LOAD   = 4'b0000;
  localparam logic [3:0] OP_ALU    = 4'b0001;
  localparam logic [3:0] OP_MOVE   = 4'b0010;
  localparam logic [3:0] OP_BRANCH = 4'b0100;
  localparam logic [3:0] OP_ALUI   = 4'b1000;
  localparam logic [3:0] OP_HALT   = 4'b1111;

  localparam int unsigned UNIT_W = 2;
  typedef logic [UNIT_W-1:0] unit_sel_t;

  localparam unit_sel_t UNIT_LOAD   = 2'd0;
  localparam unit_sel_t UNIT_MOVE   = 2'd1;
  localparam unit_sel_t UNIT_ALU    = 2'd2;
  localparam unit_sel_t UNIT_BRANCH = 2'd3;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_code_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERR    = 3'd6
`ifdef INSTR_DISPATCH_SINGLE_STEP_EN
    , ST_PAUSE = 3'd7
`endif
  } state_t;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classifier: maps opcode[15:12] to an executor index,
// or flags it as HALT or illegal. Shared with the executors.
module opcode_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode_i,
  output unit_sel_t  sel_o,
  output logic       illegal_o,
  output logic       halt_o
);

  always_comb begin
    sel_o     = UNIT_LOAD;
    illegal_o = 1'b0;
    halt_o    = 1'b0;
    case (opcode_i)
      OP_LOAD:         sel_o     = UNIT_LOAD;
      OP_MOVE:         sel_o     = UNIT_MOVE;
      OP_ALU, OP_ALUI: sel_o     = UNIT_ALU;
      OP_BRANCH:       sel_o     = UNIT_BRANCH;
      OP_HALT:         halt_o    = 1'b1;
      default:         illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_dispatch.sv
// Instruction sequencer: fetch -> decode -> one-hot executor start -> wait for done,
// with a per-instruction watchdog. INSTR_DISPATCH_SINGLE_STEP_EN adds step input and PAUSE.
module instr_dispatch
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_UNITS   = 4,
  parameter int unsigned TIMEOUT_CYC = 15,
  parameter int unsigned TMO_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 fetch_ack,
  input  logic [15:0]          instr_in,
  input  logic [NUM_UNITS-1:0] unit_done,
  input  logic                 clr_err,
`ifdef INSTR_DISPATCH_SINGLE_STEP_EN
  input  logic                 step,
`endif
  output logic                 fetch_req,
  output logic [15:0]          ir_out,
  output logic [NUM_UNITS-1:0] unit_start,
  output logic                 busy,
  output logic                 halted,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [15:0]          instr_count
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  unit_sel_t        sel_q, sel_d;
  logic [TMO_W-1:0] wdog_q, wdog_d;
  logic [15:0]      cnt_q, cnt_d;
  err_code_t        errc_q, errc_d;

  unit_sel_t dec_sel;
  logic      dec_illegal;
  logic      dec_halt;

  opcode_decode u_decode (
    .opcode_i  (ir_q[15:12]),
    .sel_o     (dec_sel),
    .illegal_o (dec_illegal),
    .halt_o    (dec_halt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      sel_q   <= UNIT_LOAD;
      wdog_q  <= '0;
      cnt_q   <= '0;
      errc_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      sel_q   <= sel_d;
      wdog_q  <= wdog_d;
      cnt_q   <= cnt_d;
      errc_q  <= errc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    sel_d   = sel_q;
    wdog_d  = wdog_q;
    cnt_d   = cnt_q;
    errc_d  = errc_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (fetch_ack) begin
          ir_d    = instr_in;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          state_d = ST_ERR;
          errc_d  = ERR_ILLEGAL;
        end else if (dec_halt) begin
          state_d = ST_HALT;
        end else begin
          sel_d   = dec_sel;
          state_d = ST_START;
        end
      end
      ST_START: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion is checked before the watchdog so a done on the last allowed cycle wins.
        if (unit_done[sel_q]) begin
          cnt_d = cnt_q + 16'd1;
`ifdef INSTR_DISPATCH_SINGLE_STEP_EN
          state_d = ST_PAUSE;
`else
          state_d = run ? ST_FETCH : ST_IDLE;
`endif
        end else if (wdog_q == TMO_LAST) begin
          state_d = ST_ERR;
          errc_d  = ERR_TIMEOUT;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_HALT: ;
      ST_ERR: begin
        if (clr_err) begin
          state_d = ST_IDLE;
          errc_d  = ERR_NONE;
        end
      end
`ifdef INSTR_DISPATCH_SINGLE_STEP_EN
      ST_PAUSE: begin
        if (step) state_d = run ? ST_FETCH : ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    unit_start = '0;
    if (state_q == ST_START) unit_start[sel_q] = 1'b1;
  end

  always_comb begin
    busy = 1'b1;
    case (state_q)
      ST_IDLE, ST_HALT, ST_ERR: busy = 1'b0;
`ifdef INSTR_DISPATCH_SINGLE_STEP_EN
      ST_PAUSE:                 busy = 1'b0;
`endif
      default:                  busy = 1'b1;
    endcase
  end

  assign fetch_req   = (state_q == ST_FETCH);
  assign halted      = (state_q == ST_HALT);
  assign err         = (state_q == ST_ERR);
  assign err_code    = errc_q;
  assign ir_out      = ir_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// Directed table-driven bench for instr_dispatch, plus hand sequences for
// fetch stall, run drop, async reset, counter wrap and HALT.
module tb_instr_dispatch;

  localparam int unsigned NU  = 4;
  localparam int unsigned TMO = 15;

  logic          clk;
  logic          rst;
  logic          run;
  logic          fetch_ack;
  logic [15:0]   instr_in;
  logic [NU-1:0] unit_done;
  logic          clr_err;
  logic          step;
  logic          fetch_req;
  logic [15:0]   ir_out;
  logic [NU-1:0] unit_start;
  logic          busy;
  logic          halted;
  logic          err;
  logic [1:0]    err_code;
  logic [15:0]   instr_count;

  instr_dispatch #(.NUM_UNITS(NU), .TIMEOUT_CYC(TMO), .TMO_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .fetch_ack   (fetch_ack),
    .instr_in    (instr_in),
    .unit_done   (unit_done),
    .clr_err     (clr_err),
`ifdef INSTR_DISPATCH_SINGLE_STEP_EN
    .step        (step),
`endif
    .fetch_req   (fetch_req),
    .ir_out      (ir_out),
    .unit_start  (unit_start),
    .busy        (busy),
    .halted      (halted),
    .err         (err),
    .err_code    (err_code),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    int          done_at;   // WAIT cycle (1-based) carrying the selected done; 0 = never
    logic [3:0]  exp_start;
    logic [3:0]  noise;     // unselected done bits pulsed on other WAIT cycles
    logic [1:0]  exp_err;
  } vec_t;

  int          n_vec;
  int          n_miss;
  logic [15:0] exp_cnt;
  vec_t        vecs[11];
  vec_t        wv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".fetch_req"},   32'(fetch_req),   32'h0);
    chk({tag, ".ir_out"},      32'(ir_out),      32'h0);
    chk({tag, ".unit_start"},  32'(unit_start),  32'h0);
    chk({tag, ".busy"},        32'(busy),        32'h0);
    chk({tag, ".halted"},      32'(halted),      32'h0);
    chk({tag, ".err"},         32'(err),         32'h0);
    chk({tag, ".err_code"},    32'(err_code),    32'h0);
    chk({tag, ".instr_count"}, 32'(instr_count), 32'h0);
  endtask

  task automatic after_done(input logic run_now);
`ifdef INSTR_DISPATCH_SINGLE_STEP_EN
    chk("pause.fetch_req", 32'(fetch_req), 32'h0);
    chk("pause.busy",      32'(busy),      32'h0);
    tick;
    chk("pause.hold",      32'(fetch_req), 32'h0);
    step = 1'b1;
    tick;
    step = 1'b0;
`endif
    chk("post_done.fetch_req", 32'(fetch_req), 32'(run_now));
    if (!run_now) chk("post_done.busy", 32'(busy), 32'h0);
  endtask

  task automatic clear_err(input logic [1:0] code);
    chk("err.flag", 32'(err),      32'h1);
    chk("err.code", 32'(err_code), 32'(code));
    chk("err.busy", 32'(busy),     32'h0);
    tick;
    chk("err.code_held", 32'(err_code), 32'(code));
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    chk("clr.err",       32'(err),       32'h0);
    chk("clr.err_code",  32'(err_code),  32'h0);
    chk("clr.fetch_req", 32'(fetch_req), 32'h0);
    tick;
  endtask

  task automatic do_vec(input vec_t v);
    chk("fetch_req", 32'(fetch_req), 32'h1);
    fetch_ack = 1'b1;
    instr_in  = v.instr;
    tick;
    fetch_ack = 1'b0;
    instr_in  = 16'h0;
    chk("decode.fetch_drop", 32'(fetch_req),  32'h0);
    chk("decode.ir_out",     32'(ir_out),     32'(v.instr));
    chk("decode.no_start",   32'(unit_start), 32'h0);
    tick;
    chk("unit_start", 32'(unit_start), 32'(v.exp_start));
    if (v.exp_err == 2'b01) begin
      clear_err(2'b01);
      return;
    end
    tick;
    chk("start_one_cycle", 32'(unit_start), 32'h0);
    for (int w = 1; w <= int'(TMO); w++) begin
      unit_done = (w == v.done_at) ? v.exp_start : v.noise;
      tick;
      unit_done = '0;
      if (w == v.done_at) begin
        exp_cnt = exp_cnt + 16'd1;
        chk("instr_count", 32'(instr_count), 32'(exp_cnt));
        after_done(run);
        return;
      end
      if (w < int'(TMO)) chk("wait.no_err", 32'(err), 32'h0);
    end
    chk("timeout.count", 32'(instr_count), 32'(exp_cnt));
    clear_err(v.exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit: bench did not finish");
    $fatal(1);
  end

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    exp_cnt = 16'h0;
    vecs[0]  = '{instr:16'h1041, done_at:1,  exp_start:4'b0100, noise:4'b0000, exp_err:2'b00};
    vecs[1]  = '{instr:16'h0123, done_at:15, exp_start:4'b0001, noise:4'b1110, exp_err:2'b00};
    vecs[2]  = '{instr:16'h2abc, done_at:3,  exp_start:4'b0010, noise:4'b0000, exp_err:2'b00};
    vecs[3]  = '{instr:16'h8001, done_at:2,  exp_start:4'b0100, noise:4'b0010, exp_err:2'b00};
    vecs[4]  = '{instr:16'h4ff0, done_at:1,  exp_start:4'b1000, noise:4'b0111, exp_err:2'b00};
    vecs[5]  = '{instr:16'h5000, done_at:0,  exp_start:4'b0000, noise:4'b0000, exp_err:2'b01};
    vecs[6]  = '{instr:16'h0123, done_at:0,  exp_start:4'b0001, noise:4'b1110, exp_err:2'b10};
    vecs[7]  = '{instr:16'h3000, done_at:0,  exp_start:4'b0000, noise:4'b0000, exp_err:2'b01};
    vecs[8]  = '{instr:16'h9000, done_at:0,  exp_start:4'b0000, noise:4'b0000, exp_err:2'b01};
    vecs[9]  = '{instr:16'he777, done_at:0,  exp_start:4'b0000, noise:4'b0000, exp_err:2'b01};
    vecs[10] = '{instr:16'h1fff, done_at:2,  exp_start:4'b0100, noise:4'b0000, exp_err:2'b00};

    rst       = 1'b0;
    run       = 1'b0;
    fetch_ack = 1'b0;
    instr_in  = 16'h0;
    unit_done = '0;
    clr_err   = 1'b0;
    step      = 1'b0;
    tick;
    chk_all_zero("reset");
    #2 rst = 1'b1;
    tick;
    chk("idle.fetch_req", 32'(fetch_req), 32'h0);
    chk("idle.busy",      32'(busy),      32'h0);
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    chk("idle.clr_no_effect", 32'(err_code), 32'h0);

    run = 1'b1;
    tick;
    for (int i = 0; i < 2; i++) begin
      chk("stall.fetch_req", 32'(fetch_req), 32'h1);
      chk("stall.busy",      32'(busy),      32'h1);
      tick;
    end

    for (int i = 0; i < 11; i++) do_vec(vecs[i]);

    // run dropped mid-instruction: instruction completes, then back to IDLE
    chk("rundrop.fetch_req", 32'(fetch_req), 32'h1);
    fetch_ack = 1'b1;
    instr_in  = 16'h2000;
    tick;
    fetch_ack = 1'b0;
    run       = 1'b0;
    tick;
    chk("rundrop.start", 32'(unit_start), 32'h2);
    tick;
    unit_done = 4'b0010;
    tick;
    unit_done = '0;
    exp_cnt = exp_cnt + 16'd1;
    chk("rundrop.count", 32'(instr_count), 32'(exp_cnt));
    after_done(1'b0);
    tick;
    chk("rundrop.idle_hold", 32'(fetch_req), 32'h0);
    run = 1'b1;
    tick;

    // asynchronous reset while waiting on an executor
    chk("rstwait.fetch_req", 32'(fetch_req), 32'h1);
    fetch_ack = 1'b1;
    instr_in  = 16'h4000;
    tick;
    fetch_ack = 1'b0;
    tick;
    tick;
    chk("rstwait.busy", 32'(busy), 32'h1);
    #2 rst = 1'b0;
    #1 chk_all_zero("rst_in_wait");
    exp_cnt = 16'h0;
    #2 rst = 1'b1;
    tick;

    // counter wrap 0xFFFF -> 0x0000
    force dut.cnt_q = 16'hFFFF;
    tick;
    release dut.cnt_q;
    exp_cnt = 16'hFFFF;
    chk("wrap.preset", 32'(instr_count), 32'hFFFF);
    wv = '{instr:16'h1041, done_at:1, exp_start:4'b0100, noise:4'b0000, exp_err:2'b00};
    do_vec(wv);
    chk("wrap.zero", 32'(instr_count), 32'h0);

    // HALT is sticky until reset
    fetch_ack = 1'b1;
    instr_in  = 16'hF000;
    tick;
    fetch_ack = 1'b0;
    tick;
    chk("halt.halted",     32'(halted),     32'h1);
    chk("halt.busy",       32'(busy),       32'h0);
    chk("halt.no_start",   32'(unit_start), 32'h0);
    for (int i = 0; i < 4; i++) begin
      run     = i[0];
      clr_err = 1'b1;
      tick;
      chk("halt.sticky",    32'(halted),    32'h1);
      chk("halt.fetch_req", 32'(fetch_req), 32'h0);
    end
    clr_err = 1'b0;
    #2 rst = 1'b0;
    #1 chk_all_zero("halt_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/instr_dispatch.md
Name: instr_dispatch

Overview:
- Top-level instruction sequencer for the microcontroller control unit.
- Fetches a 16-bit instruction into the IR and decodes opcode[15:12].
- Hands the instruction to exactly one per-class executor FSM (load, move, ALU/ALUI, branch) with a one-cycle start pulse, then waits for that executor's done.
- Guards each instruction with a watchdog and flags illegal opcodes.

Parameters:
- NUM_UNITS, 4, number of executor FSMs, fixed by the opcode map below.
- TIMEOUT_CYC, 15, maximum cycles in WAIT before a timeout error; legal range 1..2^TMO_W-1.
- TMO_W, 4, watchdog counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  enable; sampled in IDLE and at instruction completion.
- fetch_ack  in  1  instruction memory has instr_in valid this cycle.
- instr_in  in  16  instruction word.
- unit_done  in  NUM_UNITS  per-executor done pulses.
- clr_err  in  1  clears the ERR state.
- fetch_req  out  1  instruction fetch request.
- ir_out  out  16  latched instruction, broadcast to executors.
- unit_start  out  NUM_UNITS  one-hot start pulse.
- busy  out  1  high in any state except IDLE, HALT and ERR.
- halted  out  1  high in HALT.
- err  out  1  high in ERR.
- err_code  out  2  00 none, 01 illegal opcode, 10 timeout.
- instr_count  out  16  completed-instruction counter, wraps at 0xFFFF->0.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0, including ir_out, instr_count, err_code and the watchdog counter. Reset during any state aborts immediately; the start pulse is not completed.
- Opcode map: 0000 -> unit0 (load); 0010 -> unit1 (move); 0001 or 1000 -> unit2 (ALU/ALUI); 0100 -> unit3 (branch); 1111 -> HALT; all other opcodes are illegal.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH: fetch_req=1, held until fetch_ack. On the ack cycle: ir_out<=instr_in, go to DECODE. fetch_req drops the cycle after the ack.
- DECODE (1 cycle):
  - illegal opcode -> ERR, err_code<=01.
  - 1111 -> HALT.
  - otherwise latch sel and go to START.
- START (1 cycle): unit_start[sel]=1, all other bits 0; watchdog<=0; go to WAIT.
- WAIT:
  - If unit_done[sel]=1: instr_count<=instr_count+1; go to FETCH if run=1, else IDLE.
  - Else if watchdog==TIMEOUT_CYC-1: go to ERR, err_code<=10.
  - Else watchdog increments.
  - done and the timeout limit in the same cycle: done wins.
  - unit_done bits of unselected units are ignored in every state.
- HALT: halted=1. Exit only via reset.
- ERR: err=1, err_code held. If clr_err=1, go to IDLE with err_code<=00. clr_err in any other state has no effect.
- run deasserted mid-instruction: the current instruction completes normally, then the block returns to IDLE.
- Minimum instruction cost with ack in the first FETCH cycle and done in the first WAIT cycle: FETCH(1) + DECODE(1) + START(1) + WAIT(1) = 4 cycles.
- ir_out is stable from DECODE until the next fetch_ack.

Optional Feature:
- Macro: INSTR_DISPATCH_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit) and state PAUSE.
  - On instruction completion (done accepted in WAIT) the block enters PAUSE instead of FETCH/IDLE.
  - PAUSE leaves on step=1: FETCH if run=1, else IDLE.
  - busy=0 in PAUSE.
- Not defined: no step port, no PAUSE state; behaviour exactly as above.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants (OP_LOAD, OP_MOVE, OP_ALU, OP_ALUI, OP_BRANCH, OP_HALT);
  - unit index constants;
  - state encoding constants;
  - err_code constants.
- One natural sub-module: opcode_decode. It is combinational: opcode in, sel/illegal/halt out, and is reusable by the executors.

Test Plan:
- run=1; instr_in=0x1041 acked on first FETCH cycle; unit_done[2] pulses 1 cycle after START -> unit_start=0100 for exactly 1 cycle, instr_count=1, fetch_req reasserted the cycle after done.
- instr_in=0x5000 -> err=1, err_code=01, no unit_start bit set; clr_err=1 -> IDLE, err_code=00.
- instr_in=0x0123 with unit_done never asserted -> err_code=10 exactly 15 cycles after the START cycle; unit_done[0] arriving on cycle 15 instead -> no error, instr_count increments.
- unit_done[1] pulsed while sel=unit2 -> ignored, state remains WAIT; then instr_in=0xF000 -> halted=1, busy=0, remains halted despite run toggling until rst=0.
- rst driven low during WAIT -> all outputs 0 asynchronously, state IDLE; instr_count=0xFFFF plus one completion -> 0x0000.
- With INSTR_DISPATCH_SINGLE_STEP_EN: after done, fetch_req stays 0 until step=1; then fetch_req=1 on the next cycle.
